// File: rtl/led_shift_engine_pkg.sv
// led_shift_engine package: operating-mode and bounce-direction encodings
// shared by the LED shift engine, its interface users and the bench.
package led_shift_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_LEFT  = 2'b01,
        MODE_RIGHT = 2'b10,
        MODE_ROT   = 2'b11
    } shift_mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

endpackage : led_shift_pkg

// File: rtl/led_shift_engine_if.sv
// led_shift_engine_if: control/data bundle between the board-side controls
// and the LED shift engine. The slave modport is the engine's view; the
// master modport is the controlling side.
interface led_shift_engine_if #(
    parameter int WIDTH = 10
);
    logic             en;
    logic [1:0]       mode;
    logic             i_val;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] o_led;
    logic             o_tick;

    modport master (
        output en, mode, i_val, load, load_val,
        input  o_led, o_tick
    );

    modport slave (
        input  en, mode, i_val, load, load_val,
        output o_led, o_tick
    );
endinterface : led_shift_engine_if

// File: rtl/led_shift_engine_tick_gen.sv
// tick_gen: prescaler counting enabled clk cycles 0..TICK_DIV-1. step_o is
// high in the enabled cycle where the count sits at its last value; the count
// wraps on that cycle. clr (parallel load) restarts the interval.
module tick_gen #(
    parameter int TICK_DIV = 125_000_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic en,
    input  logic clr,
    output logic step_o
);
    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign step_o = en & (cnt_q == LAST);

    // Next count: clear wins, then wrap on step, then advance while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (step_o) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule : tick_gen

// File: rtl/led_shift_engine.sv
// led_shift_engine: LED shift register stepped by an internal prescaler tick.
// Modes: hold, shift left, shift right, and mode 11 which is rotate-left in
// the default build or a zero-fill bounce with a direction register when the
// macro LED_SHIFT_BOUNCE_EN is defined. Parallel load beats a step.
module led_shift_engine
    import led_shift_pkg::*;
#(
    parameter int               WIDTH     = 10,
    parameter int               TICK_DIV  = 125_000_000,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic               clk,
    input  logic               resetn,
    led_shift_engine_if.slave  bus
);
    logic             step_s;
    logic [WIDTH-1:0] led_q;
    logic [WIDTH-1:0] led_d;
    logic             tick_q;
    logic             tick_d;
`ifdef LED_SHIFT_BOUNCE_EN
    dir_e             dir_q;
    dir_e             dir_d;
`endif

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .resetn (resetn),
        .en     (bus.en),
        .clr    (bus.load),
        .step_o (step_s)
    );

    // Next LED pattern, tick strobe and bounce direction for this edge.
    always_comb begin
        led_d  = led_q;
        tick_d = 1'b0;
`ifdef LED_SHIFT_BOUNCE_EN
        dir_d  = dir_q;
`endif
        if (bus.load) begin
            led_d  = bus.load_val;
            tick_d = 1'b0;
`ifdef LED_SHIFT_BOUNCE_EN
            dir_d  = DIR_LEFT;
`endif
        end else if (step_s) begin
            tick_d = 1'b1;
            case (shift_mode_e'(bus.mode))
                MODE_HOLD:  led_d = led_q;
                MODE_LEFT:  led_d = {led_q[WIDTH-2:0], bus.i_val};
                MODE_RIGHT: led_d = {bus.i_val, led_q[WIDTH-1:1]};
                MODE_ROT: begin
`ifdef LED_SHIFT_BOUNCE_EN
                    if (led_q == '0) begin
                        led_d = {{(WIDTH-1){1'b0}}, 1'b1};
                        dir_d = DIR_LEFT;
                    end else if ((dir_q == DIR_LEFT) && led_q[WIDTH-1]) begin
                        led_d = {1'b0, led_q[WIDTH-1:1]};
                        dir_d = DIR_RIGHT;
                    end else if ((dir_q == DIR_RIGHT) && led_q[0]) begin
                        led_d = {led_q[WIDTH-2:0], 1'b0};
                        dir_d = DIR_LEFT;
                    end else if (dir_q == DIR_LEFT) begin
                        led_d = {led_q[WIDTH-2:0], 1'b0};
                    end else begin
                        led_d = {1'b0, led_q[WIDTH-1:1]};
                    end
`else
                    led_d = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
`endif
                end
                default:    led_d = led_q;
            endcase
        end else begin
            led_d  = led_q;
            tick_d = 1'b0;
        end
    end

    // LED pattern and tick strobe registers; both update on the same edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_q  <= RESET_VAL;
            tick_q <= 1'b0;
        end else begin
            led_q  <= led_d;
            tick_q <= tick_d;
        end
    end

`ifdef LED_SHIFT_BOUNCE_EN
    // Bounce direction register, persists across mode changes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dir_q <= DIR_LEFT;
        end else begin
            dir_q <= dir_d;
        end
    end
`endif

    assign bus.o_led  = led_q;
    assign bus.o_tick = tick_q;
endmodule : led_shift_engine

// File: tb/tb_led_shift_engine.sv
// Bench for led_shift_engine (WIDTH=10, TICK_DIV=4): directed scenarios with
// hand-computed expectations plus a randomized phase, all checked every cycle
// against a behavioural model of the shift rules.
module tb_led_shift_engine;
    localparam int W    = 10;
    localparam int TD   = 4;
    localparam int MASK = (1 << W) - 1;

    logic clk;
    logic resetn;

    led_shift_engine_if #(.WIDTH(W)) bus ();

    led_shift_engine #(
        .WIDTH     (W),
        .TICK_DIV  (TD),
        .RESET_VAL (10'h000)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int m_led  = 0;
    int m_cnt  = 0;
    int m_dir  = 0;   // 0 = left, 1 = right
    int m_tick = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_led  = 0;
        m_cnt  = 0;
        m_dir  = 0;
        m_tick = 0;
    endtask

    // One rising edge of the model, using the inputs held across the edge.
    task automatic model_edge();
        int v;
        if (!resetn) begin
            model_reset();
        end else if (bus.load) begin
            m_led  = int'(bus.load_val);
            m_cnt  = 0;
            m_dir  = 0;
            m_tick = 0;
        end else if (bus.en && m_cnt == TD - 1) begin
            m_cnt  = 0;
            m_tick = 1;
            v      = m_led;
            case (bus.mode)
                2'b01: m_led = ((v << 1) | int'(bus.i_val)) & MASK;
                2'b10: m_led = (v >> 1) | (int'(bus.i_val) << (W - 1));
                2'b11: begin
`ifdef LED_SHIFT_BOUNCE_EN
                    if (v == 0) begin
                        m_led = 1; m_dir = 0;
                    end else if (m_dir == 0 && v[W-1]) begin
                        m_led = v >> 1; m_dir = 1;
                    end else if (m_dir == 1 && v[0]) begin
                        m_led = (v << 1) & MASK; m_dir = 0;
                    end else if (m_dir == 0) begin
                        m_led = (v << 1) & MASK;
                    end else begin
                        m_led = v >> 1;
                    end
`else
                    m_led = ((v << 1) | (v >> (W - 1))) & MASK;
`endif
                end
                default: m_led = v;
            endcase
        end else begin
            m_tick = 0;
            if (bus.en) m_cnt = m_cnt + 1;
        end
    endtask

    // Advance one clock, update the model, then compare 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("o_led", int'(bus.o_led), m_led);
        chk("o_tick", int'(bus.o_tick), m_tick);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_load(input int val);
        bus.load     = 1'b1;
        bus.load_val = W'(val);
        cycle();
        bus.load     = 1'b0;
    endtask

    initial begin
        resetn       = 1'b0;
        bus.en       = 1'b0;
        bus.mode     = 2'b00;
        bus.i_val    = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = '0;
        model_reset();
        cycles(3);
        resetn = 1'b1;
        cycles(2);
        chk("reset_led", int'(bus.o_led), 'h000);
        chk("reset_tick", int'(bus.o_tick), 0);

        // shift left filling ones
        bus.mode = 2'b01; bus.i_val = 1'b1; bus.en = 1'b1;
        cycles(4);
        chk("left_e4", int'(bus.o_led), 'h001);
        chk("left_e4_tick", int'(bus.o_tick), 1);
        cycles(4);
        chk("left_e8", int'(bus.o_led), 'h003);
        cycles(4);
        chk("left_e12", int'(bus.o_led), 'h007);
        chk("left_e12_tick", int'(bus.o_tick), 1);

        // load all ones then shift right with zero fill
        do_load('h3FF);
        chk("load_3ff", int'(bus.o_led), 'h3FF);
        bus.mode = 2'b10; bus.i_val = 1'b0;
        cycles(4);
        chk("right_1", int'(bus.o_led), 'h1FF);
        cycles(4);
        chk("right_2", int'(bus.o_led), 'h0FF);

        // load on the step edge beats the step
        cycles(3);
        do_load('h155);
        chk("load_on_step", int'(bus.o_led), 'h155);
        chk("load_on_step_tick", int'(bus.o_tick), 0);
        cycles(3);
        chk("after_load_hold", int'(bus.o_led), 'h155);
        cycle();
        chk("after_load_step", int'(bus.o_led), 'h0AA);

        // pause with the prescaler at 2
        cycles(2);
        bus.en = 1'b0;
        cycles(10);
        chk("paused", int'(bus.o_led), 'h0AA);
        bus.en = 1'b1;
        cycle();
        chk("resume_1_tick", int'(bus.o_tick), 0);
        cycle();
        chk("resume_2", int'(bus.o_led), 'h055);
        chk("resume_2_tick", int'(bus.o_tick), 1);

        // mode 11 from 0x200
        do_load('h200);
        bus.mode = 2'b11;
        cycles(4);
`ifdef LED_SHIFT_BOUNCE_EN
        chk("bounce_1", int'(bus.o_led), 'h100);
        cycles(4);
        chk("bounce_2", int'(bus.o_led), 'h080);
        do_load('h000);
        cycles(4);
        chk("bounce_zero", int'(bus.o_led), 'h001);
`else
        chk("rot_1", int'(bus.o_led), 'h001);
        cycles(4);
        chk("rot_2", int'(bus.o_led), 'h002);
`endif

        // asynchronous reset in the middle of a cycle
        do_load('h0F0);
        bus.mode = 2'b00;
        cycles(2);
        chk("pre_reset", int'(bus.o_led), 'h0F0);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_reset_led", int'(bus.o_led), 'h000);
        chk("async_reset_tick", int'(bus.o_tick), 0);
        model_reset();
        cycles(2);
        resetn = 1'b1;

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            bus.en       = ($urandom_range(0, 9) != 0);
            bus.mode     = 2'($urandom_range(0, 3));
            bus.i_val    = 1'($urandom_range(0, 1));
            bus.load     = ($urandom_range(0, 24) == 0);
            bus.load_val = W'($urandom & MASK);
            if ($urandom_range(0, 199) == 0) begin
                resetn = 1'b0;
                cycle();
                resetn = 1'b1;
            end else begin
                cycle();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule : tb_led_shift_engine

// File: doc/led_shift_engine.md
# led_shift_engine

Parametrised LED shift-register engine with a built-in tick prescaler, clocked directly from the system clock. Replaces the fixed-width serial shifter driven by a divided clock: shifting is qualified by an internal one-cycle tick enable, and the block adds left/right/rotate modes, parallel load, run/hold control and a shift-event strobe. Sits between the board switches/buttons and the LED output vector in the top level.

## Interface
- WIDTH, 10, number of LED bits; legal range ≥ 2
- TICK_DIV, 125_000_000, clk cycles per shift step; legal range ≥ 1 (1 = every cycle)
- RESET_VAL, 0, o_led value on reset
- clk  input  1  system clock; all state on rising edge
- resetn  input  1  asynchronous, active-low reset
- en  input  1  run enable; 0 freezes prescaler and o_led
- mode  input  2  00 hold, 01 shift left, 10 shift right, 11 rotate/bounce
- i_val  input  1  serial fill bit for modes 01/10
- load  input  1  synchronous parallel-load strobe
- load_val  input  WIDTH  parallel-load data
- o_led  output  WIDTH  register contents
- o_tick  output  1  one-cycle pulse marking an o_led update by a step

## Operation
- Prescaler count cnt: 0..TICK_DIV-1. Increments when en=1; holds when en=0. Internal step = en && cnt==TICK_DIV-1; on step, cnt wraps to 0.
- Priority per edge: resetn low > load > step > hold.
- load=1: o_led ← load_val, cnt ← 0, bounce direction ← left; regardless of en or mode; o_tick stays 0.
- Step actions by mode:
  - 00: o_led unchanged; o_tick still pulses.
  - 01: o_led ← {o_led[WIDTH-2:0], i_val}.
  - 10: o_led ← {i_val, o_led[WIDTH-1:1]}.
  - 11: see Configuration.
- mode and i_val are sampled only at the step edge; mid-interval changes have no effect until then.
- Reset: o_led = RESET_VAL, o_tick = 0, cnt = 0, direction = left; asserts immediately, mid-operation included.

## Timing
- With cnt=0 and en held high from edge 0, first update at edge TICK_DIV, then every TICK_DIV edges.
- o_led and o_tick register on the same edge: o_tick high for exactly the one cycle that first shows the new o_led.
- load takes effect on its edge; the next step lands TICK_DIV enabled cycles later. load coincident with step: load wins, step discarded, o_tick 0.
- en deassertion pauses cnt mid-interval; on reassertion counting resumes from the held value (no restart).
- TICK_DIV=1: step every enabled cycle, o_tick continuously high while en=1 and load=0.

## Configuration
- Macro LED_SHIFT_BOUNCE_EN.
- Undefined: mode 11 = rotate left, o_led ← {o_led[WIDTH-2:0], o_led[WIDTH-1]}; no direction register.
- Defined: mode 11 = bounce (logical shift, zero fill, with direction register dir).
  - o_led==0: o_led ← 1 (bit 0), dir ← left.
  - dir=left and o_led[WIDTH-1]=1: dir ← right, shift right.
  - dir=right and o_led[0]=1: dir ← left, shift left.
  - Otherwise shift in dir.
  - dir persists across mode changes; cleared to left by reset or load.

## Structure
- Package led_shift_pkg: shift_mode_e enum (MODE_HOLD, MODE_LEFT, MODE_RIGHT, MODE_ROT) and the dir_e enum (DIR_LEFT, DIR_RIGHT).
- Sub-module tick_gen: prescaler (clk, resetn, en, clr, TICK_DIV) producing the step pulse; clr driven by load.
- Shift datapath and bounce logic in led_shift_engine.

## Test plan
Bench parameters: WIDTH=10, TICK_DIV=4, RESET_VAL=0.
- Reset: resetn low, then high with en=0 -> o_led=0x000, o_tick=0; asserting resetn mid-run (o_led=0x0F0) clears o_led to 0x000 immediately.
- mode=01, i_val=1, en=1 from reset -> o_led 0x001, 0x003, 0x007 at edges 4, 8, 12; o_tick high in exactly those cycles.
- load_val=0x3FF, then mode=10, i_val=0 -> 0x1FF, 0x0FF at 4 and 8 edges after load.
- load=1 on the step edge with load_val=0x155 -> o_led=0x155, o_tick=0; next change 4 edges later.
- en=0 at cnt=2 for 10 cycles, then en=1 -> no update while low; update 2 enabled edges after resume.
- Load 0x200, mode=11 -> without LED_SHIFT_BOUNCE_EN: 0x001 then 0x002; with it: 0x100, 0x080; load 0x000 -> first step gives 0x001.
